ibex_register_file_mp: RTL

Parametrised multi-port flip-flop register file, the next-generation Ibex GPR store. It provides N read ports and M write ports, with deterministic priority between write ports and optional write-to-read bypass. It also contains a sequential clear engine that wipes all words on request, and a sticky integrity/protocol error output for the alert path. It sits in the ID/WB stages in place of the single-write-port register file.

---
 rtl/ibex_pkg.sv | 19 +
 rtl/ibex_register_file_clear_ctrl.sv | 68 ++++++
 rtl/ibex_register_file_mp.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/ibex_pkg.sv
// Shared definitions for the multi-port Ibex register file.
//   rf_clr_state_e : states of the sequential clear engine
//   RF_ADDR_W      : architectural register address width (5 bits per port)
//   rf_num_words() : number of physical words for the RV32I / RV32E variants
package ibex_pkg;

    localparam int unsigned RF_ADDR_W = 5;

    typedef enum logic [1:0] {
        CLR_IDLE  = 2'd0,
        CLR_CLEAR = 2'd1,
        CLR_DONE  = 2'd2
    } rf_clr_state_e;

    function automatic int unsigned rf_num_words(bit rv32e);
        return rv32e ? 32'd16 : 32'd32;
    endfunction

endpackage

// File: rtl/ibex_register_file_clear_ctrl.sv
// Sequential wipe engine for the register file.
// Ports:
//   clk_i, rst_ni  : clock, asynchronous active-low reset
//   clear_req_i    : level request, honoured only while idle
//   clear_busy_o   : high for exactly NumWords cycles while words are wiped
//   clear_done_o   : one-cycle pulse after the last word has been wiped
//   clr_en_o       : one-hot per-word clear enable (word selected by the pointer)
module ibex_register_file_clear_ctrl
    import ibex_pkg::*;
#(
    parameter int unsigned NumWords = 32
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                clear_req_i,
    output logic                clear_busy_o,
    output logic                clear_done_o,
    output logic [NumWords-1:0] clr_en_o
);

    localparam int unsigned PtrW = $clog2(NumWords);

    rf_clr_state_e   state_q, state_d;
    logic [PtrW-1:0] ptr_q, ptr_d;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= CLR_IDLE;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
        end
    end

    // Requests arriving in CLEAR or DONE are dropped, not queued.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        unique case (state_q)
            CLR_IDLE: begin
                if (clear_req_i) begin
                    state_d = CLR_CLEAR;
                    ptr_d   = '0;
                end
            end
            CLR_CLEAR: begin
                if (ptr_q == PtrW'(NumWords - 1)) begin
                    state_d = CLR_DONE;
                end else begin
                    ptr_d = ptr_q + 1'b1;
                end
            end
            CLR_DONE: state_d = CLR_IDLE;
            default:  state_d = CLR_IDLE;
        endcase
    end

    always_comb begin
        clear_busy_o = (state_q == CLR_CLEAR);
        clear_done_o = (state_q == CLR_DONE);
        clr_en_o     = '0;
        if (state_q == CLR_CLEAR) begin
            clr_en_o[ptr_q] = 1'b1;
        end
    end

endmodule

// File: rtl/ibex_register_file_mp.sv
// Multi-port flip-flop GPR store with write priority, optional bypass,
// sequential clear engine and sticky error output.
// Ports:
//   clk_i, rst_ni              : clock, asynchronous active-low reset
//   dummy_instr_id_i/_wb_i     : dummy-instruction qualifiers for x0 read/write
//   raddr_i / rdata_o          : NumReadPorts combinational read ports (5-bit slices)
//   waddr_i / wdata_i / we_i   : NumWritePorts write ports, highest index wins
//   clear_req_i                : start a full wipe
//   clear_busy_o, clear_done_o : wipe status
//   wr_collision_o             : registered pulse on same-address multi-port write
//   err_o                      : sticky error, cleared only by reset
// Optional build macro IBEX_RF_WREN_CHECK_EN adds a duplicated, buffered
// write-enable decode that is cross-checked every cycle and feeds err_o.
module ibex_register_file_mp
    import ibex_pkg::*;
#(
    parameter int unsigned          NumReadPorts      = 2,
    parameter int unsigned          NumWritePorts     = 1,
    parameter bit                   RV32E             = 1'b0,
    parameter int unsigned          DataWidth         = 32,
    parameter bit                   DummyInstructions = 1'b0,
    parameter bit                   WrBypass          = 1'b0,
    parameter logic [DataWidth-1:0] WordZeroVal       = '0
) (
    input  logic                                clk_i,
    input  logic                                rst_ni,
    input  logic                                dummy_instr_id_i,
    input  logic                                dummy_instr_wb_i,
    input  logic [NumReadPorts*RF_ADDR_W-1:0]   raddr_i,
    output logic [NumReadPorts*DataWidth-1:0]   rdata_o,
    input  logic [NumWritePorts*RF_ADDR_W-1:0]  waddr_i,
    input  logic [NumWritePorts*DataWidth-1:0]  wdata_i,
    input  logic [NumWritePorts-1:0]            we_i,
    input  logic                                clear_req_i,
    output logic                                clear_busy_o,
    output logic                                clear_done_o,
    output logic                                wr_collision_o,
    output logic                                err_o
);

    localparam int unsigned NumWords = rf_num_words(RV32E);
    localparam int unsigned AddrW    = $clog2(NumWords);

    logic [DataWidth-1:0] words_q [NumWords];
    logic [DataWidth-1:0] words_d [NumWords];
    logic                 wr_collision_q, wr_collision_d;
    logic                 err_q, err_d;

    logic [NumWords-1:0]  clr_en;
    logic                 clear_busy;

    // Upper address bit is dropped for RV32E through the AddrW slice width.
    logic [AddrW-1:0]     waddr  [NumWritePorts];
    logic [DataWidth-1:0] wdata  [NumWritePorts];
    logic [NumWritePorts-1:0] wr_ok;
    logic [NumWords-1:0]  we_dec [NumWritePorts];
    logic                 wren_err;

    ibex_register_file_clear_ctrl #(
        .NumWords (NumWords)
    ) u_clear_ctrl (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .clear_req_i  (clear_req_i),
        .clear_busy_o (clear_busy),
        .clear_done_o (clear_done_o),
        .clr_en_o     (clr_en)
    );

    // A write is effective only outside a wipe, and x0 only for a dummy WB.
    always_comb begin
        for (int k = 0; k < NumWritePorts; k++) begin
            waddr[k]  = waddr_i[RF_ADDR_W*k +: AddrW];
            wdata[k]  = wdata_i[DataWidth*k +: DataWidth];
            wr_ok[k]  = we_i[k] && !clear_busy &&
                        ((waddr[k] != '0) || (DummyInstructions && dummy_instr_wb_i));
            we_dec[k] = '0;
            if (wr_ok[k]) begin
                we_dec[k][waddr[k]] = 1'b1;
            end
        end
    end

`ifdef IBEX_RF_WREN_CHECK_EN
    logic [NumWords-1:0] we_ref [NumWritePorts];
    logic [NumWords-1:0] we_dup [NumWritePorts];
    logic [NumWords-1:0] we_buf [NumWritePorts];

    for (genvar k = 0; k < NumWritePorts; k++) begin : g_we_buf
        prim_buf #(
            .Width (NumWords)
        ) u_we_buf (
            .in_i  (we_dup[k]),
            .out_o (we_buf[k])
        );
    end

    // Both copies decode the raw request; the buffered copy must match the
    // reference, stay one-hot and never assert without its we_i.
    always_comb begin
        wren_err = 1'b0;
        for (int k = 0; k < NumWritePorts; k++) begin
            we_ref[k] = '0;
            we_dup[k] = '0;
            if (we_i[k]) begin
                we_ref[k][waddr[k]] = 1'b1;
                we_dup[k][waddr[k]] = 1'b1;
            end
            if ((we_buf[k] != we_ref[k]) || ($countones(we_buf[k]) > 1) ||
                ((|we_buf[k]) && !we_i[k])) begin
                wren_err = 1'b1;
            end
        end
    end
`else
    assign wren_err = 1'b0;
`endif

    // Later ports overwrite earlier ones; the wipe overrides everything.
    always_comb begin
        words_d = words_q;
        for (int k = 0; k < NumWritePorts; k++) begin
            for (int i = 0; i < NumWords; i++) begin
                if (we_dec[k][i]) begin
                    words_d[i] = wdata[k];
                end
            end
        end
        for (int i = 0; i < NumWords; i++) begin
            if (clr_en[i]) begin
                words_d[i] = WordZeroVal;
            end
        end
    end

    always_comb begin
        wr_collision_d = 1'b0;
        for (int a = 0; a < NumWritePorts; a++) begin
            for (int b = a + 1; b < NumWritePorts; b++) begin
                if (we_i[a] && we_i[b] && (waddr[a] == waddr[b])) begin
                    wr_collision_d = 1'b1;
                end
            end
        end
        err_d = err_q || (clear_busy && (|we_i)) || wren_err;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < NumWords; i++) begin
                words_q[i] <= WordZeroVal;
            end
            wr_collision_q <= 1'b0;
            err_q          <= 1'b0;
        end else begin
            words_q        <= words_d;
            wr_collision_q <= wr_collision_d;
            err_q          <= err_d;
        end
    end

    logic [AddrW-1:0]     raddr [NumReadPorts];
    logic [DataWidth-1:0] rdata [NumReadPorts];

    // wr_ok already excludes wipe cycles and non-dummy x0 writes, so the
    // bypass needs only the read-side x0 rule on top of it.
    always_comb begin
        rdata_o = '0;
        for (int p = 0; p < NumReadPorts; p++) begin
            raddr[p] = raddr_i[RF_ADDR_W*p +: AddrW];
            rdata[p] = words_q[raddr[p]];
            if ((raddr[p] == '0) && !(DummyInstructions && dummy_instr_id_i)) begin
                rdata[p] = WordZeroVal;
            end else if (WrBypass) begin
                for (int k = 0; k < NumWritePorts; k++) begin
                    if (wr_ok[k] && (waddr[k] == raddr[p])) begin
                        rdata[p] = wdata[k];
                    end
                end
            end
            rdata_o[DataWidth*p +: DataWidth] = rdata[p];
        end
    end

    assign clear_busy_o   = clear_busy;
    assign wr_collision_o = wr_collision_q;
    assign err_o          = err_q;

endmodule
